alu_spi_responder: RTL

- SPI responder (slave) end of the processor-to-ALU serial link.
- Deserialises a request packet {operand_b, operand_a, op} from the processor and presents it to an ALU execution core through a valid/ready-style handshake.
- Captures the core's result and serialises it back as a start marker followed by the result bits.
- Sits between the Spi interface signals and the combinational/multicycle ALU datapath.

---
 rtl/alu_spi_responder_if.sv | 22 ++
 rtl/alu_spi_responder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/alu_spi_responder_if.sv
// Request/result handshake between the SPI responder (master side) and the ALU core (slave side).
interface alu_spi_responder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 4
);
  logic                  o_req_valid;
  logic [OP_WIDTH-1:0]   o_op;
  logic [DATA_WIDTH-1:0] o_operand_a;
  logic [DATA_WIDTH-1:0] o_operand_b;
  logic                  i_result_valid;
  logic [DATA_WIDTH-1:0] i_result;

  modport master (
    output o_req_valid, o_op, o_operand_a, o_operand_b,
    input  i_result_valid, i_result
  );

  modport slave (
    input  o_req_valid, o_op, o_operand_a, o_operand_b,
    output i_result_valid, i_result
  );
endinterface

// File: rtl/alu_spi_responder.sv
// SPI responder for the processor-to-ALU link: receives {operand_b, operand_a, op}, hands it to the
// core, then returns a start marker plus the result LSB first. Optional macro: ALU_RESP_TIMEOUT_EN.
module alu_spi_responder #(
  parameter int DATA_WIDTH     = 8,
  parameter int OP_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_nss,
  input  logic                 i_mosi,
  output logic                 o_miso,
  alu_spi_responder_if.master  alu
);

  localparam int PACKET_WIDTH = OP_WIDTH + 2 * DATA_WIDTH;
  localparam int CNT_MAX      = (PACKET_WIDTH > DATA_WIDTH) ? PACKET_WIDTH : DATA_WIDTH;
  localparam int CNT_W        = $clog2(CNT_MAX);
  localparam int RIDX_W       = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] CNT_PKT_LAST = CNT_W'(PACKET_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_RES_LAST = CNT_W'(DATA_WIDTH - 1);

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    RECEIVING,
    REQUEST,
    SEND_START,
    SENDING
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [PACKET_WIDTH-1:0] packet;
  logic [PACKET_WIDTH-1:0] packet_next;
  logic [DATA_WIDTH-1:0]   result;
  logic                    tmo_expired;

  // Includes the bit arriving this edge so the outputs load the complete packet on entry to REQUEST.
  always_comb begin
    packet_next      = packet;
    packet_next[cnt] = i_mosi;
  end

`ifdef ALU_RESP_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_expired = (tmo_cnt == TMO_LAST);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      tmo_cnt <= '0;
    end else if (state == REQUEST && !i_nss && !alu.i_result_valid && !tmo_expired) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state           <= IDLE;
      cnt             <= '0;
      packet          <= '0;
      result          <= '0;
      alu.o_req_valid <= 1'b0;
      alu.o_op        <= '0;
      alu.o_operand_a <= '0;
      alu.o_operand_b <= '0;
    end else if (state != IDLE && i_nss) begin
      // Deselect aborts from any state and beats every other transition.
      state           <= IDLE;
      cnt             <= '0;
      alu.o_req_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!i_nss && i_mosi) begin
            state <= RECEIVING;
            cnt   <= '0;
          end
        end
        RECEIVING: begin
          packet <= packet_next;
          if (cnt == CNT_PKT_LAST) begin
            state           <= REQUEST;
            cnt             <= '0;
            alu.o_req_valid <= 1'b1;
            alu.o_op        <= packet_next[OP_WIDTH-1:0];
            alu.o_operand_a <= packet_next[OP_WIDTH +: DATA_WIDTH];
            alu.o_operand_b <= packet_next[OP_WIDTH + DATA_WIDTH +: DATA_WIDTH];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REQUEST: begin
          if (alu.i_result_valid) begin
            result          <= alu.i_result;
            state           <= SEND_START;
            alu.o_req_valid <= 1'b0;
          end else if (tmo_expired) begin
            result          <= '1;
            state           <= SEND_START;
            alu.o_req_valid <= 1'b0;
          end
        end
        SEND_START: begin
          state <= SENDING;
          cnt   <= '0;
        end
        SENDING: begin
          if (cnt == CNT_RES_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Decoded from state so the marker and bit 0 line up with the processor's sampling edges.
  always_comb begin
    case (state)
      SEND_START: o_miso = 1'b1;
      SENDING:    o_miso = result[cnt[RIDX_W-1:0]];
      default:    o_miso = 1'b0;
    endcase
  end

endmodule
